// File: rtl/or1200_vlx_pkg.sv
// Shared types and constants for the VLX bit packer.
// The packer top and its word assembler both import this package.
package or1200_vlx_pkg;

  localparam int VLX_MAX_LEN = 24;
  localparam int VLX_LEN_W   = $clog2(VLX_MAX_LEN + 1);

  typedef enum logic [2:0] {
    RUN,
    PAD,
    DRAIN,
    STUFF,
    LAST,
    DONE
  } vlx_pack_state_t;

  // Byte enables for a partial word holding cnt bytes, filled from [31:24] down.
  function automatic logic [3:0] vlx_be_from_cnt(input logic [1:0] cnt);
    return ~(4'hF >> cnt);
  endfunction

endpackage

// File: rtl/or1200_vlx_wordasm.sv
// Byte-to-word assembler for the VLX packer: collects bytes MSB-first into a
// big-endian 32-bit word and holds it on a valid/ready handshake. A close
// request turns the bytes collected so far into a partial word with byte enables.
module or1200_vlx_wordasm
  import or1200_vlx_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  logic [7:0]  byte_i,
  input  logic        close_i,
  output logic        ready_o,
  output logic [1:0]  byte_cnt_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o,
  output logic [3:0]  out_be_o
);

  logic [1:0]  r_cnt;
  logic        r_valid;
  logic [31:0] r_data;
  logic [3:0]  r_be;

  assign ready_o     = !r_valid;
  assign byte_cnt_o  = r_cnt;
  assign out_valid_o = r_valid;
  assign out_data_o  = r_data;
  assign out_be_o    = r_be;

  // Word fill, close and handshake; a held word blocks further bytes until taken.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_be    <= '0;
    end else if (r_valid) begin
      if (out_ready_i) r_valid <= 1'b0;
    end else if (close_i && (r_cnt != 2'd0)) begin
      r_valid <= 1'b1;
      r_be    <= vlx_be_from_cnt(r_cnt);
      r_cnt   <= '0;
    end else if (push_i) begin
      // The first byte of a word clears the rest so partial words carry zero padding.
      if (r_cnt == 2'd0) r_data <= {byte_i, 24'h000000};
      else               r_data[8*(2'd3 - r_cnt) +: 8] <= byte_i;
      if (r_cnt == 2'd3) begin
        r_valid <= 1'b1;
        r_be    <= 4'hF;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/or1200_vlx_bitpack.sv
// VLX bit packer: appends variable-length codes MSB-first into a left-aligned
// bit buffer, extracts one byte per cycle into the word assembler, and on flush
// pads the last byte with 1s and closes the final partial word.
// Build option: define VLX_BYTE_STUFF_EN to insert 0x00 after every 0xFF byte.
module or1200_vlx_bitpack
  import or1200_vlx_pkg::*;
#(
  parameter  int MAX_LEN = VLX_MAX_LEN,
  localparam int LEN_W   = $clog2(MAX_LEN + 1),
  localparam int BUF_W   = MAX_LEN + 7
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [MAX_LEN-1:0] in_code_i,
  input  logic [LEN_W-1:0]   in_len_i,
  input  logic               flush_i,
  output logic               flush_done_o,
  output logic               busy_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [31:0]        out_data_o,
  output logic [3:0]         out_be_o
);

  localparam int CNT_W = $clog2(BUF_W + 1);

  logic [BUF_W-1:0]   r_buf;
  logic [CNT_W-1:0]   r_bit_cnt;
  vlx_pack_state_t    r_state;
  vlx_pack_state_t    w_state_nxt;
`ifdef VLX_BYTE_STUFF_EN
  vlx_pack_state_t    r_ret_state;
`endif

  logic [LEN_W-1:0]   w_len;
  logic [MAX_LEN-1:0] w_code_mask;
  logic [CNT_W-1:0]   w_shamt;
  logic [BUF_W-1:0]   w_code_pos;
  logic [7:0]         w_top_byte;
  logic [7:0]         w_push_byte;
  logic               w_accept;
  logic               w_want_extract;
  logic               w_extract;
  logic               w_pad;
  logic               w_push;
  logic               w_close;
  logic               w_asm_ready;
  logic [1:0]         w_asm_cnt;

  // Over-long lengths are clamped; the masked code lands right below the pending bits.
  assign w_len       = (in_len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : in_len_i;
  assign w_code_mask = ~({MAX_LEN{1'b1}} << w_len);
  assign w_shamt     = CNT_W'(BUF_W) - r_bit_cnt - CNT_W'(w_len);
  assign w_code_pos  = BUF_W'(in_code_i & w_code_mask) << w_shamt;
  assign w_top_byte  = r_buf[BUF_W-1 -: 8];

  // Input is taken only while less than a byte is pending, so a full-length code always fits.
  assign in_ready_o   = (r_state == RUN) && (r_bit_cnt < CNT_W'(8));
  assign flush_done_o = (r_state == DONE);
  assign busy_o       = (r_bit_cnt != '0) || (w_asm_cnt != 2'd0) || out_valid_o || (r_state != RUN);

  // Next-state and per-cycle datapath controls.
  always_comb begin
    w_state_nxt    = r_state;
    w_accept       = 1'b0;
    w_want_extract = 1'b0;
    w_extract      = 1'b0;
    w_pad          = 1'b0;
    w_push         = 1'b0;
    w_push_byte    = w_top_byte;
    w_close        = 1'b0;
    case (r_state)
      RUN: begin
        if (in_ready_o) begin
          w_accept = in_valid_i;
          if (flush_i) w_state_nxt = PAD;
        end else begin
          w_want_extract = 1'b1;
        end
      end
      // A code accepted together with the flush may leave whole bytes; drain those before padding.
      PAD: begin
        if (r_bit_cnt >= CNT_W'(8)) w_want_extract = 1'b1;
        else begin
          w_pad       = 1'b1;
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (r_bit_cnt == '0) w_state_nxt = LAST;
        else                 w_want_extract = 1'b1;
      end
`ifdef VLX_BYTE_STUFF_EN
      STUFF: begin
        if (w_asm_ready) begin
          w_push      = 1'b1;
          w_push_byte = 8'h00;
          w_state_nxt = r_ret_state;
        end
      end
`endif
      LAST: begin
        if (!out_valid_o) begin
          if (w_asm_cnt == 2'd0) w_state_nxt = DONE;
          else                   w_close     = 1'b1;
        end
      end
      DONE:    w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
    if (w_want_extract && w_asm_ready && (r_bit_cnt >= CNT_W'(8))) begin
      w_extract = 1'b1;
      w_push    = 1'b1;
`ifdef VLX_BYTE_STUFF_EN
      if (w_top_byte == 8'hFF) w_state_nxt = STUFF;
`endif
    end
  end

  // State register; the stuff state remembers where to resume.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= RUN;
`ifdef VLX_BYTE_STUFF_EN
      r_ret_state <= RUN;
`endif
    end else begin
      r_state <= w_state_nxt;
`ifdef VLX_BYTE_STUFF_EN
      if ((w_state_nxt == STUFF) && (r_state != STUFF)) r_ret_state <= r_state;
`endif
    end
  end

  // Bit buffer: append, byte extract and 1-fill padding are mutually exclusive.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_buf     <= '0;
      r_bit_cnt <= '0;
    end else if (w_accept) begin
      r_buf     <= r_buf | w_code_pos;
      r_bit_cnt <= r_bit_cnt + CNT_W'(w_len);
    end else if (w_extract) begin
      r_buf     <= r_buf << 8;
      r_bit_cnt <= r_bit_cnt - CNT_W'(8);
    end else if (w_pad && (r_bit_cnt != '0)) begin
      r_buf[BUF_W-1 -: 8] <= w_top_byte | (8'hFF >> r_bit_cnt);
      r_bit_cnt           <= CNT_W'(8);
    end
  end

  or1200_vlx_wordasm u_wordasm (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (w_push),
    .byte_i      (w_push_byte),
    .close_i     (w_close),
    .ready_o     (w_asm_ready),
    .byte_cnt_o  (w_asm_cnt),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_be_o    (out_be_o)
  );

endmodule

// File: tb/tb_or1200_vlx_bitpack.sv
// Self-checking bench for or1200_vlx_bitpack: a bit-queue reference model
// predicts output words at accept time, a monitor compares them on handshake.
// Follows VLX_BYTE_STUFF_EN the same way as the design.
module tb_or1200_vlx_bitpack;
  import or1200_vlx_pkg::*;

  localparam int MAX_LEN = VLX_MAX_LEN;
  localparam int LEN_W   = VLX_LEN_W;

  logic               clk = 1'b0;
  logic               rst_ni = 1'b0;
  logic               in_valid_i = 1'b0;
  logic               in_ready_o;
  logic [MAX_LEN-1:0] in_code_i = '0;
  logic [LEN_W-1:0]   in_len_i = '0;
  logic               flush_i = 1'b0;
  logic               flush_done_o;
  logic               busy_o;
  logic               out_valid_o;
  logic               out_ready_i = 1'b0;
  logic [31:0]        out_data_o;
  logic [3:0]         out_be_o;

  int n_vec = 0;
  int n_err = 0;
  int exp_done = 0;
  int seen_done = 0;
  int rdy_mode = 0;

  logic [35:0] exp_q[$];
  bit          mbits[$];
  logic [7:0]  mbytes[$];

  or1200_vlx_bitpack dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_code_i    (in_code_i),
    .in_len_i     (in_len_i),
    .flush_i      (flush_i),
    .flush_done_o (flush_done_o),
    .busy_o       (busy_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_data_o   (out_data_o),
    .out_be_o     (out_be_o)
  );

  always #5 clk = ~clk;

  task automatic fail(input string nm, input logic [35:0] act, input logic [35:0] exp);
    n_err++;
    $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    n_vec++;
    if (act !== exp) fail(nm, act, exp);
  endtask

  // ---------------- reference model ----------------
  task automatic m_emit(input logic [7:0] b);
    logic [31:0] w;
    mbytes.push_back(b);
`ifdef VLX_BYTE_STUFF_EN
    if (b == 8'hFF) mbytes.push_back(8'h00);
`endif
    while (mbytes.size() >= 4) begin
      w = '0;
      for (int i = 0; i < 4; i++) w = {w[23:0], mbytes.pop_front()};
      exp_q.push_back({4'hF, w});
    end
  endtask

  task automatic m_bits_to_bytes();
    logic [7:0] b;
    while (mbits.size() >= 8) begin
      b = '0;
      for (int i = 0; i < 8; i++) b = {b[6:0], mbits.pop_front()};
      m_emit(b);
    end
  endtask

  task automatic m_code(input logic [MAX_LEN-1:0] code, input int len);
    int l;
    l = (len > MAX_LEN) ? MAX_LEN : len;
    for (int i = l - 1; i >= 0; i--) mbits.push_back(code[i]);
    m_bits_to_bytes();
  endtask

  task automatic m_flush();
    logic [31:0] w;
    logic [3:0]  be;
    int          n;
    while ((mbits.size() % 8) != 0) mbits.push_back(1'b1);
    m_bits_to_bytes();
    n = mbytes.size();
    if (n > 0) begin
      w  = '0;
      be = '0;
      for (int i = 0; i < 4; i++) begin
        if (i < n) begin w = {w[23:0], mbytes[i]}; be = {be[2:0], 1'b1}; end
        else       begin w = {w[23:0], 8'h00};     be = {be[2:0], 1'b0}; end
      end
      exp_q.push_back({be, w});
      mbytes.delete();
    end
    exp_done++;
  endtask

  // ---------------- drivers ----------------
  task automatic send(input logic [MAX_LEN-1:0] code, input int len, input bit fl, input bit v = 1'b1);
    in_valid_i = v;
    in_code_i  = code;
    in_len_i   = LEN_W'(len);
    flush_i    = fl;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (in_ready_o) begin
        if (v)  m_code(code, len);
        if (fl) m_flush();
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        flush_i    = 1'b0;
        return;
      end
    end
    fail("send_timeout", 36'd0, 36'd1);
    in_valid_i = 1'b0;
    flush_i    = 1'b0;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (!busy_o && (exp_q.size() == 0)) begin
        @(posedge clk); #1;
        return;
      end
    end
    fail("idle_timeout", 36'(busy_o), 36'd0);
  endtask

  // Consumer ready: random, forced low (stall) or forced high.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready_i = ($urandom_range(0, 3) != 0);
        1:       out_ready_i = 1'b0;
        default: out_ready_i = 1'b1;
      endcase
    end
  end

  // Monitor: scoreboard pop on handshake, hold stability, flush_done pulse width.
  initial begin
    logic        prev_stall;
    logic        prev_done;
    logic [35:0] prev_out;
    logic [35:0] e;
    prev_stall = 1'b0;
    prev_done  = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        prev_stall = 1'b0;
        prev_done  = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", 36'(out_valid_o), 36'd1);
          chk("hold_word", {out_be_o, out_data_o}, prev_out);
        end
        if (flush_done_o) begin
          seen_done++;
          if (prev_done) fail("flush_done_width", 36'd2, 36'd1);
        end
        if (out_valid_o && out_ready_i) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            fail("unexpected_word", {out_be_o, out_data_o}, 36'd0);
          end else begin
            e = exp_q.pop_front();
            chk("word", {out_be_o, out_data_o}, e);
          end
        end
        prev_stall = out_valid_o && !out_ready_i;
        prev_done  = flush_done_o;
        prev_out   = {out_be_o, out_data_o};
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int k;
    logic [MAX_LEN-1:0] c;
    int l;
    bit fl;
    bit v;

    rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",   36'(in_ready_o),   36'd1);
    chk("rst_out_valid",  36'(out_valid_o),  36'd0);
    chk("rst_busy",       36'(busy_o),       36'd0);
    chk("rst_flush_done", 36'(flush_done_o), 36'd0);
    chk("rst_data",       36'(out_data_o),   36'd0);
    chk("rst_be",         36'(out_be_o),     36'd0);
    rst_ni = 1'b1;
    @(posedge clk); #1;

    // Three codes forming one full word.
    send(24'b101, 3, 1'b0);
    send(24'b11111, 5, 1'b0);
    send(24'h123456, 24, 1'b0);
    wait_idle();

    // 0xFF data byte, then flush.
    send(24'hFF, 8, 1'b0);
    send(24'hAB, 8, 1'b0);
    send(24'hCD, 8, 1'b0);
    send('0, 0, 1'b1, 1'b0);
    wait_idle();

    // Single 0 bit padded with ones.
    send(24'h0, 1, 1'b0);
    send('0, 0, 1'b1, 1'b0);
    wait_idle();

    // Zero-length code with flush on an empty buffer.
    send(24'h5A5A5A, 0, 1'b1);
    k = 0;
    for (int t = 0; t < 20; t++) begin
      k++;
      if (flush_done_o) break;
      @(posedge clk); #1;
    end
    chk("flush_latency", 36'(k - 1), 36'd3);
    wait_idle();

    // 40 bits under a consumer stall.
    rdy_mode = 1;
    send(24'hC0FFEE, 16, 1'b0);
    send(24'h00BEEF, 16, 1'b0);
    send(24'h000042, 8, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("stall_in_ready", 36'(in_ready_o), 36'd0);
    end
    chk("stall_valid", 36'(out_valid_o), 36'd1);
    rdy_mode = 0;
    send('0, 0, 1'b1, 1'b0);
    wait_idle();

    // Reset with a held word and 12 pending bits.
    rdy_mode = 1;
    send(24'hA1B2C3, 24, 1'b0);
    send(24'h0000D4, 8, 1'b0);
    send(24'h000EEE, 12, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    chk("pre_rst_busy",     36'(busy_o),      36'd1);
    chk("pre_rst_valid",    36'(out_valid_o), 36'd1);
    chk("pre_rst_in_ready", 36'(in_ready_o),  36'd0);
    rst_ni = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_out_valid", 36'(out_valid_o),  36'd0);
    chk("mid_rst_busy",      36'(busy_o),       36'd0);
    chk("mid_rst_data",      36'(out_data_o),   36'd0);
    chk("mid_rst_be",        36'(out_be_o),     36'd0);
    chk("mid_rst_in_ready",  36'(in_ready_o),   36'd1);
    chk("mid_rst_done",      36'(flush_done_o), 36'd0);
    exp_q.delete();
    mbits.delete();
    mbytes.delete();
    rst_ni = 1'b1;
    rdy_mode = 0;
    @(posedge clk); #1;

    // Randomized traffic with occasional flushes, all-ones codes and over-long lengths.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) l = $urandom_range(25, 31);
      else                           l = $urandom_range(0, 24);
      c = MAX_LEN'($urandom);
      if ($urandom_range(0, 4) == 0) c = '1;
      fl = ($urandom_range(0, 15) == 0);
      v  = fl ? 1'($urandom_range(0, 1)) : 1'b1;
      if ($urandom_range(0, 19) == 0) rdy_mode = 2;
      else if ($urandom_range(0, 19) == 0) rdy_mode = 0;
      send(c, l, fl, v);
    end
    rdy_mode = 0;
    send('0, 0, 1'b1, 1'b0);
    wait_idle();

    chk("queue_drained", 36'(exp_q.size()), 36'd0);
    chk("flush_done_count", 36'(seen_done), 36'(exp_done));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
